// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared state encoding and data-memory geometry for the arbiter
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_BURST = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  localparam int DM_WORDS = 1024;
  localparam int WIDX_HI  = 11;
  localparam int WIDX_LO  = 2;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - CPU, EXT and memory-side signal bundle of the data-memory arbiter
interface dm_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic        ext_we;
  logic        ext_lock;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic        ext_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rdata, ext_rvalid, ext_err,
    output mem_we, mem_addr, mem_wdata, mem_pc
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rdata, ext_rvalid, ext_err,
    input  mem_we, mem_addr, mem_wdata, mem_pc
  );
endinterface

// File: rtl/dm_arb_sel.sv
// rtl/dm_arb_sel.sv - combinational port selection and memory-side mux
module dm_arb_sel
  import dm_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
  parameter logic [31:0] EXT_PC     = 32'h0000_0000
) (
  input  logic        reset,
  input  state_t      state,
  input  logic        starve,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_pc,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic        ext_lock,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        sel_ext,
  output logic        ext_oor,
  output logic        cpu_stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc
);

  always_comb begin
    sel_ext = 1'b0;
    case (state)
      S_CPU:   sel_ext = ext_req & (~cpu_req | starve);
      S_BURST: sel_ext = ext_req & ext_lock;
      S_COOL:  sel_ext = ext_req & ~cpu_req;
      default: sel_ext = 1'b0;
    endcase
    // Reset blocks every access, including an in-flight burst beat.
    if (reset) sel_ext = 1'b0;

    ext_oor   = (ext_addr >= ADDR_LIMIT);
    cpu_stall = cpu_req & sel_ext;

    if (sel_ext) begin
      mem_we    = ext_we & ~ext_oor;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_pc    = EXT_PC;
    end else begin
      mem_we    = cpu_req & cpu_we & ~reset;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_pc    = cpu_pc;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data-memory arbiter between the M stage and an external loader port
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned MAX_BURST  = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
  parameter logic [31:0] EXT_PC     = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic       BURST_EN  = (MAX_BURST > 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  burst_cnt;
  logic        sel_ext;
  logic        ext_oor;
  logic        starve;
  logic [31:0] ext_rdata_q;
  logic        ext_rvalid_q;
  logic        ext_err_q;

  assign starve         = (wait_cnt == WAIT_MAX);
  assign bus.ext_gnt    = sel_ext;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_err    = ext_err_q;

  dm_arb_sel #(
    .ADDR_LIMIT (ADDR_LIMIT),
    .EXT_PC     (EXT_PC)
  ) u_sel (
    .reset     (reset),
    .state     (state),
    .starve    (starve),
    .cpu_req   (bus.cpu_req),
    .cpu_we    (bus.cpu_we),
    .cpu_addr  (bus.cpu_addr),
    .cpu_wdata (bus.cpu_wdata),
    .cpu_pc    (bus.cpu_pc),
    .ext_req   (bus.ext_req),
    .ext_we    (bus.ext_we),
    .ext_lock  (bus.ext_lock),
    .ext_addr  (bus.ext_addr),
    .ext_wdata (bus.ext_wdata),
    .sel_ext   (sel_ext),
    .ext_oor   (ext_oor),
    .cpu_stall (bus.cpu_stall),
    .mem_we    (bus.mem_we),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_pc    (bus.mem_pc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_CPU, S_COOL: state_nxt = (sel_ext & bus.ext_lock & BURST_EN) ? S_BURST : S_CPU;
      // burst_cnt counts beats already granted, so +1 is the beat in progress.
      S_BURST: begin
        if (!(bus.ext_req & bus.ext_lock) || (burst_cnt + 4'd1 == BURST_MAX))
          state_nxt = S_COOL;
      end
      default: state_nxt = S_CPU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sel_ext || !bus.ext_req) begin
      wait_cnt <= 4'd0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= 4'd0;
    end else if (sel_ext) begin
      if (state == S_BURST) burst_cnt <= burst_cnt + 4'd1;
      else if (bus.ext_lock) burst_cnt <= 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_rdata_q  <= 32'd0;
      ext_rvalid_q <= 1'b0;
      ext_err_q    <= 1'b0;
    end else begin
      ext_rvalid_q <= sel_ext & ~bus.ext_we;
      ext_err_q    <= sel_ext & ext_oor;
      if (sel_ext && !bus.ext_we) ext_rdata_q <= ext_oor ? 32'd0 : bus.mem_rdata;
    end
  end

endmodule
